// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter in front of a USB UART transmit input.
// Each requester owns the line until it sends LF or goes idle too long.
module uart_tx_arbiter #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       owner,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [7:0]  mem_q [2][DEPTH];
  logic [AW:0] wr_q [2];
  logic [AW:0] rd_q [2];
  logic [7:0]  in_dat [2];
  logic [7:0]  head [2];
  logic [1:0]  in_vld;
  logic [1:0]  empty;
  logic [1:0]  full;
  logic [1:0]  push;
  logic [1:0]  pop;

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sel;
  logic        hs;

  assign in_vld    = {req1_valid, req0_valid};
  assign in_dat[0] = req0_data;
  assign in_dat[1] = req1_data;

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      empty[n] = (wr_q[n] == rd_q[n]);
      full[n]  = ((wr_q[n] - rd_q[n]) == FULLC);
      push[n]  = in_vld[n] && !full[n] && !RST;
      head[n]  = mem_q[n][rd_q[n][AW-1:0]];
    end
  end

  assign req0_ready = !full[0] && !RST;
  assign req1_ready = !full[1] && !RST;

  assign sel       = (state_q == GRANT1);
  assign busy      = (state_q != IDLE);
  assign owner     = sel;
  assign out_valid = busy && !empty[sel];
  assign out_data  = busy ? head[sel] : 8'h00;
  assign hs        = out_valid && out_ready;
  assign pop       = {hs && sel, hs && !sel};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int n = 0; n < 2; n++) begin
        wr_q[n] <= '0;
        rd_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n]) wr_q[n] <= wr_q[n] + ONE;
        if (pop[n])  rd_q[n] <= rd_q[n] + ONE;
      end
    end
  end

  // Storage needs no reset; pointers alone define occupancy.
  always_ff @(posedge CLK) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) mem_q[n][wr_q[n][AW-1:0]] <= in_dat[n];
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        cnt_d = '0;
        if (!empty[0] && !empty[1])
          state_d = last_q ? GRANT0 : GRANT1;
        else if (!empty[0])
          state_d = GRANT0;
        else if (!empty[1])
          state_d = GRANT1;
      end
      (state_q == GRANT0 || state_q == GRANT1): begin
        if (hs) begin
          cnt_d = '0;
          if (out_data == 8'h0A) begin
            state_d = IDLE;
            last_d  = sel;
          end
        end else if (empty[sel]) begin
          // Stalled-by-sink cycles do not age the owner.
          cnt_d = cnt_q + 16'd1;
          if (cnt_d >= TMO) begin
            state_d = IDLE;
            last_d  = sel;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_uart_tx_arbiter;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       v0 = 1'b0;
  logic       v1 = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;
  logic       o_ready = 1'b0;
  logic       req0_ready, req1_ready;
  logic       out_valid, owner, busy;
  logic [7:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(v0), .req0_data(d0), .req0_ready(req0_ready),
    .req1_valid(v1), .req1_data(d1), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(o_ready),
    .owner(owner), .busy(busy)
  );

  typedef struct {
    logic       r0, r1, bz, ow, ov;
    logic [7:0] od;
    bit         e_r0, e_r1, e_bz, e_ow, e_ov;
    bit [7:0]   e_od;
    bit         v0, ordy;
  } obs_t;

  obs_t       lg[$];
  logic [8:0] got[$];
  bit         acc0;

  // Reference model: per-requester byte queues and line ownership.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  int m_own;
  int m_last;
  int m_cnt;

  function automatic int qsz(int n);
    return (n == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [7:0] qhd(int n);
    if (n == 0) return mq0[0];
    return mq1[0];
  endfunction

  function automatic logic [7:0] nolf();
    logic [7:0] b;
    b = 8'($urandom);
    return (b == 8'h0A) ? 8'h0B : b;
  endfunction

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_own  = -1;
    m_last = 1;
    m_cnt  = 0;
  endtask

  task automatic model_tick();
    bit a0, a1;
    logic [7:0] b;
    a0 = v0 && (qsz(0) < DEPTH);
    a1 = v1 && (qsz(1) < DEPTH);
    if (m_own < 0) begin
      m_cnt = 0;
      if (qsz(0) > 0 && qsz(1) > 0) m_own = 1 - m_last;
      else if (qsz(0) > 0) m_own = 0;
      else if (qsz(1) > 0) m_own = 1;
    end else if (qsz(m_own) > 0 && o_ready) begin
      if (m_own == 0) b = mq0.pop_front();
      else b = mq1.pop_front();
      m_cnt = 0;
      if (b == 8'h0A) begin
        m_last = m_own;
        m_own  = -1;
      end
    end else if (qsz(m_own) == 0) begin
      m_cnt++;
      if (m_cnt >= TMO) begin
        m_last = m_own;
        m_own  = -1;
        m_cnt  = 0;
      end
    end
    if (a0) mq0.push_back(d0);
    if (a1) mq1.push_back(d1);
  endtask

  // One clock: observe at negedge, advance model, return after posedge.
  task automatic adv();
    obs_t o;
    @(negedge CLK);
    o.r0 = req0_ready; o.r1 = req1_ready;
    o.bz = busy; o.ow = owner;
    o.ov = out_valid; o.od = out_data;
    o.e_r0 = qsz(0) < DEPTH;
    o.e_r1 = qsz(1) < DEPTH;
    o.e_bz = m_own >= 0;
    o.e_ow = m_own == 1;
    o.e_ov = 1'b0;
    o.e_od = 8'h00;
    if (m_own >= 0 && qsz(m_own) > 0) begin
      o.e_ov = 1'b1;
      o.e_od = qhd(m_own);
    end
    o.v0 = v0;
    o.ordy = o_ready;
    lg.push_back(o);
    acc0 = v0 && req0_ready;
    model_tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic collect();
    got.delete();
    foreach (lg[i])
      if (lg[i].ov && lg[i].ordy) got.push_back({lg[i].ow, lg[i].od});
  endtask

  task automatic do_reset();
    RST = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    lg.delete();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    v0 = 1'b1; v1 = 1'b1;
    d0 = 8'h55; d1 = 8'h66;
    o_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
    end
    n_cmp++;
    if ({out_valid, busy, owner} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_out got %b want 000", {out_valid, busy, owner});
    end
    @(negedge CLK);
    RST = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL post_reset_ready got %b want 11", {req0_ready, req1_ready});
    end
    n_cmp++;
    if ({out_valid, busy, owner} !== 3'b000) begin
      n_bad++;
      $display("FAIL post_reset_idle got %b want 000", {out_valid, busy, owner});
    end
  endtask

  task automatic test_single_stream();
    logic [7:0] hi[3] = '{8'h48, 8'h69, 8'h0A};
    int fv;
    do_reset();
    o_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v0 = 1'b1; d0 = hi[i];
      adv();
    end
    v0 = 1'b0;
    repeat (5) adv();
    fv = -1;
    foreach (lg[i]) if (fv < 0 && lg[i].ov) fv = i;
    n_cmp++;
    if (fv != 2) begin
      n_bad++;
      $display("FAIL single_latency got %0d want 2", fv);
    end
    collect();
    n_cmp++;
    if (got.size() != 3) begin
      n_bad++;
      $display("FAIL single_count got %0d want 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== {1'b0, hi[i]}) begin
        n_bad++;
        $display("FAIL single_byte%0d got %h want %h", i, got[i], {1'b0, hi[i]});
      end
    end
    n_cmp++;
    if ({lg[4].bz, lg[5].bz} !== 2'b10) begin
      n_bad++;
      $display("FAIL single_busy_fall got %b want 10", {lg[4].bz, lg[5].bz});
    end
  endtask

  task automatic test_contention();
    logic [8:0] e1[4] = '{9'h041, 9'h00A, 9'h142, 9'h10A};
    logic [8:0] e2[4] = '{9'h043, 9'h00A, 9'h144, 9'h10A};
    do_reset();
    o_ready = 1'b1;
    v0 = 1'b1; d0 = 8'h41; v1 = 1'b1; d1 = 8'h42;
    adv();
    d0 = 8'h0A; d1 = 8'h0A;
    adv();
    v0 = 1'b0; v1 = 1'b0;
    repeat (8) adv();
    collect();
    n_cmp++;
    if (got.size() != 4) begin
      n_bad++;
      $display("FAIL cont1_count got %0d want 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== e1[i]) begin
        n_bad++;
        $display("FAIL cont1_hs%0d got %h want %h", i, got[i], e1[i]);
      end
    end
    lg.delete();
    v0 = 1'b1; d0 = 8'h43; v1 = 1'b1; d1 = 8'h44;
    adv();
    d0 = 8'h0A; d1 = 8'h0A;
    adv();
    v0 = 1'b0; v1 = 1'b0;
    repeat (8) adv();
    collect();
    n_cmp++;
    if (got.size() != 4) begin
      n_bad++;
      $display("FAIL cont2_count got %0d want 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== e2[i]) begin
        n_bad++;
        $display("FAIL cont2_hs%0d got %h want %h", i, got[i], e2[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b[5];
    int k;
    for (int i = 0; i < 5; i++) b[i] = nolf();
    do_reset();
    o_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      v0 = (k < 5);
      if (k < 5) d0 = b[k];
      adv();
      if (acc0) k++;
    end
    n_cmp++;
    if ({lg[3].r0, lg[4].r0} !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_ready got %b want 10", {lg[3].r0, lg[4].r0});
    end
    n_cmp++;
    if (k != 4) begin
      n_bad++;
      $display("FAIL bp_accepts got %0d want 4", k);
    end
    for (int c = 2; c < 20; c++) begin
      n_cmp++;
      if ({lg[c].bz, lg[c].ov, lg[c].od} !== {2'b11, b[0]}) begin
        n_bad++;
        $display("FAIL bp_hold cyc %0d got %b/%b/%h want 1/1/%h",
                 c, lg[c].bz, lg[c].ov, lg[c].od, b[0]);
      end
    end
    o_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      v0 = (k < 5);
      if (k < 5) d0 = b[k];
      adv();
      if (acc0) k++;
    end
    v0 = 1'b0;
    collect();
    n_cmp++;
    if (got.size() != 5) begin
      n_bad++;
      $display("FAIL bp_drain_count got %0d want 5", got.size());
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== {1'b0, b[i]}) begin
        n_bad++;
        $display("FAIL bp_drain%0d got %h want %h", i, got[i], {1'b0, b[i]});
      end
    end
  endtask

  task automatic test_timeout();
    int h;
    do_reset();
    o_ready = 1'b1;
    v0 = 1'b1; d0 = 8'h41; v1 = 1'b1; d1 = 8'h42;
    adv();
    v0 = 1'b0; v1 = 1'b0;
    repeat (16) adv();
    h = -1;
    foreach (lg[i])
      if (h < 0 && lg[i].ov && lg[i].ordy && lg[i].od == 8'h41) h = i;
    n_cmp++;
    if (h != 2) begin
      n_bad++;
      $display("FAIL tmo_first_hs got %0d want 2", h);
    end
    if (h >= 0) begin
      n_cmp++;
      if ({lg[h+TMO].bz, lg[h+TMO].ow} !== 2'b10) begin
        n_bad++;
        $display("FAIL tmo_still_owned got %b want 10",
                 {lg[h+TMO].bz, lg[h+TMO].ow});
      end
      n_cmp++;
      if (lg[h+TMO+1].bz !== 1'b0) begin
        n_bad++;
        $display("FAIL tmo_release got %b want 0", lg[h+TMO+1].bz);
      end
      n_cmp++;
      if ({lg[h+TMO+2].bz, lg[h+TMO+2].ow, lg[h+TMO+2].ov, lg[h+TMO+2].od}
          !== {3'b111, 8'h42}) begin
        n_bad++;
        $display("FAIL tmo_switch got %b%b%b/%h want 111/42",
                 lg[h+TMO+2].bz, lg[h+TMO+2].ow, lg[h+TMO+2].ov,
                 lg[h+TMO+2].od);
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [7:0] L[4];
    for (int i = 0; i < 3; i++) L[i] = nolf();
    L[3] = 8'h0A;
    do_reset();
    o_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v1 = 1'b1; d1 = L[i];
      adv();
    end
    collect();
    n_cmp++;
    if (got.size() != 2 || got[0] !== {1'b1, L[0]} || got[1] !== {1'b1, L[1]}) begin
      n_bad++;
      $display("FAIL mid_pre_bytes got %0d bytes want 2 (%h %h)",
               got.size(), L[0], L[1]);
    end
    n_cmp++;
    if ({out_valid, busy, owner} !== 3'b111) begin
      n_bad++;
      $display("FAIL mid_pre_state got %b want 111", {out_valid, busy, owner});
    end
    v0 = 1'b1; d0 = 8'h77;
    RST = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready, out_valid, busy, owner} !== 5'b00000) begin
      n_bad++;
      $display("FAIL mid_rst_outs got %b want 00000",
               {req0_ready, req1_ready, out_valid, busy, owner});
    end
    do_reset();
    repeat (12) adv();
    n_cmp++;
    if ({lg[0].r0, lg[0].r1} !== 2'b11) begin
      n_bad++;
      $display("FAIL mid_ready_after got %b want 11", {lg[0].r0, lg[0].r1});
    end
    v1 = 1'b1; d1 = 8'h5A;
    adv();
    v1 = 1'b0;
    repeat (6) adv();
    collect();
    n_cmp++;
    if (got.size() != 1 || got[0] !== 9'h15A) begin
      n_bad++;
      $display("FAIL mid_leftover got %0d bytes want exactly 15a", got.size());
    end
  endtask

  task automatic test_simul_enq_deq();
    logic [7:0] s[12];
    int k, acc_t, pop_t;
    for (int i = 0; i < 12; i++) s[i] = nolf();
    do_reset();
    o_ready = 1'b0;
    k = 0; acc_t = 0; pop_t = 0;
    for (int c = 0; c < 3; c++) begin
      v0 = (c < 2);
      d0 = s[k];
      adv();
      if (acc0) k++;
    end
    o_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      v0 = 1'b1;
      d0 = s[k];
      adv();
      if (acc0) k++;
      acc_t = 0; pop_t = 0;
      foreach (lg[i]) begin
        if (lg[i].v0 && lg[i].r0) acc_t++;
        if (lg[i].ov && lg[i].ordy) pop_t++;
      end
      n_cmp++;
      if (acc_t - pop_t != 2) begin
        n_bad++;
        $display("FAIL simul_count cyc %0d got %0d want 2", c, acc_t - pop_t);
      end
    end
    v0 = 1'b0;
    repeat (15) adv();
    collect();
    n_cmp++;
    if (got.size() != 12) begin
      n_bad++;
      $display("FAIL simul_total got %0d want 12", got.size());
    end
    for (int i = 0; i < 12 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== {1'b0, s[i]}) begin
        n_bad++;
        $display("FAIL simul_byte%0d got %h want %h", i, got[i], {1'b0, s[i]});
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v0 = 1'($urandom % 2);
      v1 = 1'($urandom % 2);
      d0 = ($urandom % 5 == 0) ? 8'h0A : nolf();
      d1 = ($urandom % 5 == 0) ? 8'h0A : nolf();
      o_ready = ($urandom % 4) != 0;
      adv();
    end
    v0 = 1'b0; v1 = 1'b0;
    foreach (lg[i]) begin
      n_cmp++;
      if ({lg[i].r0, lg[i].r1, lg[i].bz, lg[i].ow, lg[i].ov} !==
          {lg[i].e_r0, lg[i].e_r1, lg[i].e_bz, lg[i].e_ow, lg[i].e_ov}) begin
        n_bad++;
        $display("FAIL rand_ctl cyc %0d got %b want %b", i,
                 {lg[i].r0, lg[i].r1, lg[i].bz, lg[i].ow, lg[i].ov},
                 {lg[i].e_r0, lg[i].e_r1, lg[i].e_bz, lg[i].e_ow, lg[i].e_ov});
      end
      if (lg[i].e_ov) begin
        n_cmp++;
        if (lg[i].od !== lg[i].e_od) begin
          n_bad++;
          $display("FAIL rand_data cyc %0d got %h want %h",
                   i, lg[i].od, lg[i].e_od);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_stream();
    test_contention();
    test_backpressure();
    test_timeout();
    test_reset_midline();
    test_simul_enq_deq();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, per-requester FIFO depth in bytes (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 255, idle cycles before an owned line is released (1..65535).
REQ-003 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0_valid  input  1 and req0_data  input  8: requester 0 (core) byte offer.
REQ-006 SHALL have port req0_ready  output  1  requester 0 byte accepted this cycle when high with req0_valid.
REQ-007 SHALL have ports req1_valid  input  1, req1_data  input  8, req1_ready  output  1: requester 1 (debug/boot source), same rules.
REQ-008 SHALL have ports out_valid  output  1 and out_data  output  8: byte to USB UART input.
REQ-009 SHALL have port out_ready  input  1  USB UART accepts byte when high with out_valid.
REQ-010 SHALL have port owner  output  1  index of granted requester, valid only when busy=1.
REQ-011 SHALL have port busy  output  1  high when a requester owns the line.

Function
REQ-012 SHALL buffer each requester in its own DEPTH-entry FIFO; reqN_ready = !fullN (no enqueue while full, no bypass).
REQ-013 SHALL enqueue on reqN_valid && reqN_ready; enqueued byte visible to arbiter the following cycle.
REQ-014 SHALL allow simultaneous enqueue and dequeue on the same FIFO when neither full nor empty; count unchanged.
REQ-015 SHALL use states IDLE, GRANT0, GRANT1; busy = (state != IDLE); owner = 1 in GRANT1, else 0.
REQ-016 SHALL in IDLE: if exactly one FIFO non-empty, go GRANTn for it; if both, grant the requester not equal to last-granted pointer; if none, stay.
REQ-017 SHALL in IDLE hold out_valid = 0.
REQ-018 SHALL in GRANTn drive out_valid = !emptyN and out_data = headN (combinational from FIFO head); never present the other FIFO.
REQ-019 SHALL dequeue headN on out_valid && out_ready.
REQ-020 SHALL on a handshake of byte 0x0A (LF) go IDLE next cycle and set last-granted pointer to n.
REQ-021 SHALL keep timeout counter (16 bits): cleared on entering GRANTn and on every handshake; increments each GRANTn cycle with emptyN; holds while out_valid && !out_ready.
REQ-022 SHALL when counter reaches TIMEOUT go IDLE next cycle, set last-granted pointer to n; counter cleared.
REQ-023 SHALL give LF release precedence; LF and timeout in same cycle release once.
REQ-024 SHALL keep out_valid/out_data stable while out_valid && !out_ready (head not changed by enqueue to non-empty FIFO).
REQ-025 SHALL have latency: byte enqueued cycle 0 into empty system appears on out_valid in cycle 2 (IDLE->GRANT decided in cycle 1).
REQ-026 SHALL never drop, duplicate or reorder bytes within a requester stream.

Reset
REQ-027 SHALL on RST high immediately: FIFOs empty, state IDLE, last-granted pointer 1 (requester 0 preferred first), counter 0.
REQ-028 SHALL hold req0_ready = req1_ready = 0, out_valid = 0, busy = 0, owner = 0 while RST high.
REQ-029 SHALL discard buffered bytes on RST asserted mid-line; first byte after release follows REQ-016.
REQ-030 SHALL resume normal operation on first rising CLK edge after RST deasserts.

Verification
REQ-031 SHALL test single stream: req0 sends "Hi\n" (0x48,0x69,0x0A), out_ready=1 -> out_data 0x48 in cycle 2, bytes in order, busy falls cycle after 0x0A.
REQ-032 SHALL test contention: both load "A\n" and "B\n" same cycle after reset -> req0 line fully out first, then req1; next contention grants req0 again after req1 was last.
REQ-033 SHALL test backpressure: out_ready=0 with req0 pushing 5 bytes, DEPTH=4 -> req0_ready low after 4 accepts, out_data held 1st byte, no timeout; out_ready=1 drains all 5 in order.
REQ-034 SHALL test timeout: TIMEOUT=8, req0 sends 0x41 with no LF, req1 waiting -> owner switches to 1 exactly 8 empty cycles after 0x41 handshake plus 1.
REQ-035 SHALL test reset mid-line: RST asserted after 2 of 4 bytes of req1 line -> outputs/readies 0 same cycle, FIFOs empty, no leftover bytes after release.
REQ-036 SHALL test simultaneous enqueue/dequeue at count 2 -> count stays 2 over 10 cycles, stream intact.
